// File: rtl/dcache_tag_ctrl_pkg.sv
// dcache_tag_ctrl_pkg: default field widths, controller states and address-field positions
package dcache_tag_ctrl_pkg;
  localparam int TAG_W_DEF = 20;
  localparam int IDX_W_DEF = 9;
  localparam int OFS_W_DEF = 3;
  localparam int IDX_LSB = OFS_W_DEF;
  localparam int TAG_LSB = OFS_W_DEF + IDX_W_DEF;
  typedef enum logic [2:0] {FLUSH, IDLE, LOOKUP, MISS, WAIT, UPDATE, RESP} state_e;
endpackage

// File: rtl/dcache_tag_ctrl_if.sv
// dcache_tag_ctrl_if: lookup request/response and line-refill handshakes
interface dcache_tag_ctrl_if #(parameter int IDX_W = dcache_tag_ctrl_pkg::IDX_W_DEF);
  logic req_valid, req_ready;
  logic [31:0] req_addr;
  logic resp_valid, resp_hit;
  logic [IDX_W-1:0] resp_index;
  logic refill_req_valid, refill_req_ready, refill_done;
  logic [31:0] refill_addr;
  modport master (
    output req_valid, req_addr, refill_req_ready, refill_done,
    input  req_ready, resp_valid, resp_hit, resp_index, refill_req_valid, refill_addr
  );
  modport slave (
    input  req_valid, req_addr, refill_req_ready, refill_done,
    output req_ready, resp_valid, resp_hit, resp_index, refill_req_valid, refill_addr
  );
endinterface

// File: rtl/dcache_tag_ctrl.sv
// dcache_tag_ctrl: direct-mapped tag lookup, refill sequencing and flush over an external tag RAM
// Optional hit/miss counters are built when DCACHE_TAG_CTRL_STATS_EN is defined.
module dcache_tag_ctrl
  import dcache_tag_ctrl_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int OFS_W = OFS_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  dcache_tag_ctrl_if.slave bus,
  input  logic             flush_req_i,
  output logic             flush_busy_o,
  output logic [TAG_W:0]   tag_wr_data_o,
  output logic [IDX_W-1:0] tag_wr_addr_o,
  output logic             tag_wr_en_o,
  output logic [IDX_W-1:0] tag_rd_addr_o,
  input  logic [TAG_W:0]   tag_rd_data_i
`ifdef DCACHE_TAG_CTRL_STATS_EN
  ,
  output logic [31:0]      hit_cnt_o,
  output logic [31:0]      miss_cnt_o
`endif
);
  state_e state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic hit_q, hit_d;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic accept, lookup_hit, unused_ofs;
  assign tag = addr_q[OFS_W+IDX_W +: TAG_W];
  assign idx = addr_q[OFS_W +: IDX_W];
  assign unused_ofs = ^addr_q[OFS_W-1:0];
  assign lookup_hit = tag_rd_data_i[TAG_W] && tag_rd_data_i[TAG_W-1:0] == tag;
  // RESP also accepts so a hit can be followed back-to-back by the next lookup
  assign bus.req_ready = (state_q == IDLE && !flush_req_i) || state_q == RESP;
  assign accept = bus.req_valid && bus.req_ready;
  assign tag_rd_addr_o = accept ? bus.req_addr[OFS_W +: IDX_W] : idx;
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_hit = hit_q;
  assign bus.resp_index = idx;
  assign bus.refill_req_valid = state_q == MISS;
  assign bus.refill_addr = {addr_q[31:OFS_W], {OFS_W{1'b0}}};
  assign flush_busy_o = state_q == FLUSH;
  assign tag_wr_en_o = rst_n && (state_q == FLUSH || state_q == UPDATE);
  assign tag_wr_addr_o = state_q == FLUSH ? cnt_q : idx;
  assign tag_wr_data_o = state_q == FLUSH ? '0 : {1'b1, tag};
  always_comb begin
    state_d = state_q;
    addr_d = accept ? bus.req_addr : addr_q;
    hit_d = hit_q;
    cnt_d = state_q == FLUSH ? cnt_q + 1'b1 : '0;
    case (state_q)
      FLUSH:   state_d = &cnt_q ? IDLE : FLUSH;
      IDLE:    state_d = flush_req_i ? FLUSH : accept ? LOOKUP : IDLE;
      LOOKUP: begin
        hit_d = lookup_hit;
        state_d = lookup_hit ? RESP : MISS;
      end
      MISS:    state_d = bus.refill_req_ready ? WAIT : MISS;
      WAIT:    state_d = bus.refill_done ? UPDATE : WAIT;
      UPDATE: begin
        hit_d = 1'b0;
        state_d = RESP;
      end
      RESP:    state_d = accept ? LOOKUP : IDLE;
      default: state_d = FLUSH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FLUSH;
      cnt_q <= '0;
      addr_q <= '0;
      hit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      hit_q <= hit_d;
    end
  end
`ifdef DCACHE_TAG_CTRL_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic clr;
  assign clr = state_q == IDLE && flush_req_i;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q <= clr ? '0 : hit_cnt_q + 32'(bus.resp_valid && hit_q);
      miss_cnt_q <= clr ? '0 : miss_cnt_q + 32'(bus.resp_valid && !hit_q);
    end
  end
  assign hit_cnt_o = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif
endmodule

// File: doc/dcache_tag_ctrl.md
DCACHE_TAG_CTRL -- requirements
Module: dcache_tag_ctrl

Interface
REQ-001 Parameter TAG_W, default 20, tag field width; a tag RAM entry is {valid, tag}, TAG_W+1 = 21 bits.
REQ-002 Parameter IDX_W, default 9, index width; 512 tag RAM entries.
REQ-003 Parameter OFS_W, default 3, line offset width; TAG_W+IDX_W+OFS_W SHALL equal 32.
REQ-004 clk  in  1  single clock for all logic and for both tag RAM ports.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid / req_ready  in / out  1 / 1  lookup request handshake.
REQ-007 req_addr  in  32  byte address: tag=[31:12], index=[11:3], offset=[2:0].
REQ-008 resp_valid / resp_hit  out  1 / 1  one-cycle response pulse; hit=1 for hit, 0 for a miss after refill.
REQ-009 resp_index  out  IDX_W  index of the responded request.
REQ-010 flush_req  in  1  request to invalidate all entries; flush_busy  out  1  high while flushing.
REQ-011 refill_req_valid / refill_req_ready  out / in  1 / 1  line refill request handshake.
REQ-012 refill_addr  out  32  line-aligned miss address (offset bits zero); refill_done  in  1  one-cycle completion pulse.
REQ-013 tag_wr_data / tag_wr_addr / tag_wr_en  out  21 / IDX_W / 1  tag RAM write port.
REQ-014 tag_rd_addr / tag_rd_data  out / in  IDX_W / 21  tag RAM read port; read data valid one cycle after the address (no output register).

Function
REQ-015 States SHALL be FLUSH, IDLE, LOOKUP, MISS, WAIT, UPDATE, RESP.
REQ-016 FLUSH: a 9-bit counter 0..511 writes 21'b0 at one entry per cycle; flush_busy=1; req_ready=0; after entry 511 -> IDLE; 512 cycles total.
REQ-017 IDLE: req_ready = !flush_req; flush_req SHALL take priority over req_valid in the same cycle -> FLUSH with counter cleared.
REQ-018 On accept (req_valid&req_ready at cycle T): latch req_addr; tag_rd_addr = req_addr[11:3] combinationally in cycle T and held afterwards; -> LOOKUP.
REQ-019 LOOKUP (T+1): hit = tag_rd_data[20] & (tag_rd_data[19:0]==latched tag); hit -> RESP with resp_hit=1; miss -> MISS.
REQ-020 Hit latency: resp_valid SHALL be high in cycle T+2; req_ready high again in T+2 (RESP -> IDLE).
REQ-021 MISS: refill_req_valid=1 with refill_addr={tag,index,3'b0}, held stable until refill_req_ready; then -> WAIT.
REQ-022 WAIT: on refill_done -> UPDATE; refill_done in any other state SHALL be ignored.
REQ-023 UPDATE: one cycle with tag_wr_en=1, tag_wr_addr=index, tag_wr_data={1'b1,tag}; -> RESP with resp_hit=0.
REQ-024 flush_req outside IDLE SHALL be ignored (no queuing).
REQ-025 tag_wr_en SHALL be asserted only in FLUSH and UPDATE.

Reset
REQ-026 Asynchronous assertion of rst_n low SHALL force state FLUSH, counter 0, resp_valid=0, refill_req_valid=0, tag_wr_en=0, req_ready=0, flush_busy=1, latched address 0.
REQ-027 Reset mid-refill SHALL abandon the refill; a later refill_done SHALL be ignored; the flush restarts from entry 0.

Configuration
REQ-028 With DCACHE_TAG_CTRL_STATS_EN defined: outputs hit_cnt and miss_cnt (32 bits each, wrap at 2^32, cleared by reset and on FLUSH entry) SHALL increment once per hit and per miss response.
REQ-029 Without DCACHE_TAG_CTRL_STATS_EN: these ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-030 The shared package SHALL hold TAG_W/IDX_W/OFS_W defaults, the state enumeration and the address-field slice constants.
REQ-031 A single flat module; the tag RAM itself SHALL be instantiated by the parent, not inside this block.

Verification
REQ-032 Reset release -> flush_busy=1 for exactly 512 cycles, writes to addresses 0..511 with data 0, then req_ready=1.
REQ-033 Lookup 0x0000_1008 on an empty cache -> refill_addr=0x0000_1008, after refill_done a write {1,20'h00001} at index 1, resp_hit=0, resp_index=1.
REQ-034 Repeat lookup 0x0000_100C -> resp_valid in T+2 with resp_hit=1, no refill request.
REQ-035 Lookup 0x0000_2008 (same index, different tag) -> miss, entry 1 overwritten with {1,20'h00002}.
REQ-036 flush_req and req_valid in the same IDLE cycle -> req not accepted, 512-cycle flush, then the prior hit address misses.
REQ-037 rst_n low while in WAIT, refill_done pulsed afterwards -> no tag write outside the flush, no resp_valid; with DCACHE_TAG_CTRL_STATS_EN, hit_cnt=miss_cnt=0.
